// File: rtl/fire_control_unit.sv
// fire_control_unit: lock/fire/cooldown sequencer with missile inventory and range gate
module fire_control_unit #(
    parameter int INIT_MISSILES   = 4,
    parameter int MAX_RANGE       = 12000,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        target_locked,
    input  logic [13:0] distance_to_target,
    input  logic        fire_command,
    output logic        launch_missile,
    output logic [3:0]  remaining_missiles,
    output logic [13:0] engaged_distance,
    output logic [1:0]  FCU_state
);
    localparam logic [1:0] IDLE        = 2'b00;
    localparam logic [1:0] LOCKED      = 2'b01;
    localparam logic [1:0] FIRE        = 2'b10;
    localparam logic [1:0] OUT_OF_AMMO = 2'b11;
    localparam int CW = $clog2(COOLDOWN_CYCLES);
    localparam logic [13:0]   MAX_DIST = 14'(MAX_RANGE);
    localparam logic [CW-1:0] LAST     = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [3:0]    INIT     = 4'(INIT_MISSILES);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          fire_q, in_range, engageable, fire_edge;

    assign FCU_state = state;

    // Engagement gate and rising-edge detect on the operator request
    always_comb begin
        in_range   = (distance_to_target != 14'd0) && (distance_to_target <= MAX_DIST);
        engageable = target_locked && in_range;
        fire_edge  = fire_command && !fire_q;
    end

    // Engagement FSM; losing the lock in LOCKED wins over a simultaneous fire edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            fire_q             <= 1'b0;
            launch_missile     <= 1'b0;
            remaining_missiles <= INIT;
            engaged_distance   <= '0;
        end else begin
            fire_q         <= fire_command;
            launch_missile <= 1'b0;
            case (state)
                IDLE: if (engageable) begin
                    state            <= LOCKED;
                    engaged_distance <= distance_to_target;
                end
                LOCKED: if (!engageable) begin
                    state <= IDLE;
                end else begin
                    engaged_distance <= distance_to_target;
                    if (fire_edge && remaining_missiles != 4'd0) begin
                        state              <= FIRE;
                        launch_missile     <= 1'b1;
                        remaining_missiles <= remaining_missiles - 4'd1;
                        cnt                <= '0;
                    end
                end
                FIRE: if (cnt == LAST) begin
                    cnt   <= '0;
                    state <= remaining_missiles == 4'd0 ? OUT_OF_AMMO : engageable ? LOCKED : IDLE;
                    if (remaining_missiles != 4'd0 && engageable) engaged_distance <= distance_to_target;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fire_control_unit.sv
// tb_fire_control_unit: directed scenarios plus random stimulus against a behavioural model
module tb_fire_control_unit;
    localparam int INIT = 4;
    localparam int MAXR = 12000;
    localparam int COOL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        target_locked = 1'b0;
    logic [13:0] distance_to_target = '0;
    logic        fire_command = 1'b0;
    logic        launch_missile;
    logic [3:0]  remaining_missiles;
    logic [13:0] engaged_distance;
    logic [1:0]  FCU_state;

    int checks = 0;
    int errors = 0;

    // behavioural model: mode 0 idle, 1 locked, 2 firing, 3 empty
    int m_mode, m_ammo, m_eng, m_cool_left, m_launch;
    bit m_prev_fire;
    int launches;

    fire_control_unit #(.INIT_MISSILES(INIT), .MAX_RANGE(MAXR), .COOLDOWN_CYCLES(COOL)) dut (
        .clk(clk), .rst(rst), .target_locked(target_locked),
        .distance_to_target(distance_to_target), .fire_command(fire_command),
        .launch_missile(launch_missile), .remaining_missiles(remaining_missiles),
        .engaged_distance(engaged_distance), .FCU_state(FCU_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ammo = INIT; m_eng = 0; m_cool_left = 0; m_launch = 0; m_prev_fire = 0;
    endtask

    task automatic model_step(input bit l, input int d, input bit f);
        bit ok, rise;
        ok = l && d > 0 && d <= MAXR;
        rise = f && !m_prev_fire;
        m_prev_fire = f;
        m_launch = 0;
        if (m_mode == 0) begin
            if (ok) begin m_mode = 1; m_eng = d; end
        end else if (m_mode == 1) begin
            if (!ok) m_mode = 0;
            else begin
                m_eng = d;
                if (rise && m_ammo > 0) begin
                    m_mode = 2; m_ammo = m_ammo - 1; m_launch = 1; m_cool_left = COOL;
                end
            end
        end else if (m_mode == 2) begin
            m_cool_left = m_cool_left - 1;
            if (m_cool_left == 0) begin
                if (m_ammo == 0) m_mode = 3;
                else if (ok) begin m_mode = 1; m_eng = d; end
                else m_mode = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, int'(FCU_state), m_mode);
        chk({tag, ".launch"}, int'(launch_missile), m_launch);
        chk({tag, ".ammo"}, int'(remaining_missiles), m_ammo);
        chk({tag, ".eng"}, int'(engaged_distance), m_eng);
    endtask

    task automatic cyc(input string tag, input bit l, input int d, input bit f);
        target_locked = l;
        distance_to_target = 14'(d);
        fire_command = f;
        @(posedge clk);
        model_step(l, d, f);
        #1;
        if (launch_missile) launches++;
        check_all(tag);
    endtask

    // asserts rst between edges, holds it across one edge, releases mid-cycle
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".instant"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // lock and fire at 4500
        launches = 0;
        cyc("lf_idle0", 1, 4500, 0);
        cyc("lf_lock1", 1, 4500, 0);
        cyc("lf_fire", 1, 4500, 1);
        chk("lf_launch_pulse", int'(launch_missile), 1);
        for (int i = 0; i < COOL; i++) cyc("lf_cool", 1, 4500, 0);
        chk("lf_back_locked", int'(FCU_state), 1);
        chk("lf_one_launch", launches, 1);
        chk("lf_ammo3", int'(remaining_missiles), 3);

        // range gate
        async_reset("rg_rst");
        cyc("rg_12001", 1, 12001, 0);
        chk("rg_12001_idle", int'(FCU_state), 0);
        cyc("rg_0", 1, 0, 0);
        chk("rg_0_idle", int'(FCU_state), 0);
        cyc("rg_12000", 1, 12000, 0);
        chk("rg_12000_locked", int'(FCU_state), 1);
        chk("rg_eng", int'(engaged_distance), 12000);

        // lock loss vs fire edge
        cyc("ll_drop", 0, 12000, 1);
        chk("ll_no_launch", int'(launch_missile), 0);
        chk("ll_ammo", int'(remaining_missiles), INIT);
        chk("ll_eng_held", int'(engaged_distance), 12000);

        // held fire, then exhaust inventory
        async_reset("ex_rst");
        launches = 0;
        cyc("ex_lock", 1, 3000, 0);
        for (int i = 0; i < 3 * COOL; i++) cyc("ex_hold", 1, 3000, 1);
        chk("ex_single", launches, 1);
        for (int k = 0; k < 3; k++) begin
            cyc("ex_low", 1, 3000, 0);
            cyc("ex_high", 1, 3000, 1);
            for (int i = 0; i < COOL; i++) cyc("ex_cool", 1, 3000, 0);
        end
        chk("ex_four", launches, 4);
        chk("ex_empty_ammo", int'(remaining_missiles), 0);
        chk("ex_empty_state", int'(FCU_state), 3);
        for (int i = 0; i < 6; i++) cyc("ex_ignored", 1, 3000, i[0]);
        chk("ex_still_four", launches, 4);

        // lock lost during cooldown
        async_reset("lc_rst");
        cyc("lc_lock", 1, 5000, 0);
        cyc("lc_fire", 1, 5000, 1);
        cyc("lc_c2", 1, 5000, 0);
        cyc("lc_c3", 0, 5000, 0);
        for (int i = 3; i < COOL; i++) cyc("lc_cool", 0, 5000, 0);
        chk("lc_fire_last", int'(FCU_state), 2);
        cyc("lc_exit", 0, 5000, 0);
        chk("lc_idle", int'(FCU_state), 0);

        // async reset mid-fire, then fire held across release
        cyc("ar_lock", 1, 7000, 0);
        cyc("ar_fire", 1, 7000, 1);
        cyc("ar_c1", 1, 7000, 1);
        fire_command = 1'b1;
        async_reset("ar_mid");
        chk("ar_ammo", int'(remaining_missiles), INIT);
        launches = 0;
        cyc("ar_relock", 1, 7000, 1);
        cyc("ar_held", 1, 7000, 1);
        cyc("ar_held2", 1, 7000, 1);
        chk("ar_no_launch", launches, 0);
        cyc("ar_low", 1, 7000, 0);
        cyc("ar_new_edge", 1, 7000, 1);
        chk("ar_launch", launches, 1);

        // random stimulus
        begin
            bit l, f;
            int d;
            l = 1; f = 0; d = 4000;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0)
                    case ($urandom_range(0, 5))
                        0: d = 0;
                        1: d = MAXR;
                        2: d = MAXR + 1;
                        3: d = 1;
                        4: d = $urandom_range(12002, 16383);
                        default: d = $urandom_range(1, MAXR);
                    endcase
                if ($urandom_range(0, 3) == 0) f = !f;
                if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
                cyc("rnd", l, d, f);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
